// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_OK  = 3'd1,
        GOT_CMD = 3'd2,
        GOT_DH  = 3'd3,
        GOT_DL  = 3'd4,
        PEND    = 3'd5
    } state_t;

    localparam logic [1:0] ERR_CSUM = 2'b01;
    localparam logic [1:0] ERR_TO   = 2'b10;
    localparam logic [1:0] ERR_OVR  = 2'b11;

    localparam logic [7:0] DEFAULT_HEADER      = 8'hAA;
    localparam int         DEFAULT_TIMEOUT_CYC = 50000;

    // 8-bit sum, carries discarded
    function automatic logic [7:0] frame_csum(input logic [7:0] c,
                                              input logic [7:0] dh,
                                              input logic [7:0] dl);
        return c + dh + dl;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte timeout: reloads on clear, counts down while enabled, flags
// expiry once the full window has elapsed without a reload.
module uart_byte_timer
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int TO_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TO_W-1:0] LOAD_VAL = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= LOAD_VAL;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - TO_W'(1);
        end
    end

    assign expire = enable && (cnt == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame assembler/validator behind the UART byte receiver; hands validated
// commands downstream over valid/ack and reports frame errors.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | hunting for the header byte
//   HDR_OK  | header seen, waiting for command byte
//   GOT_CMD | command latched, waiting for data high
//   GOT_DH  | data high latched, waiting for data low
//   GOT_DL  | data low latched, waiting for checksum
//   PEND    | command presented on cmd_*, waiting for ack
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] HEADER      = DEFAULT_HEADER,
    parameter int         TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int         TO_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_ready,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [15:0] cmd_data,
    input  logic        cmd_ack,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic [7:0]  frame_cnt,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    state_t     state;
    logic [7:0] cmd_r;
    logic [7:0] dh_r;
    logic [7:0] dl_r;
    logic       in_frame;
    logic       to_clear;
    logic       to_expire;

    assign in_frame = (state == HDR_OK) || (state == GOT_CMD) ||
                      (state == GOT_DH) || (state == GOT_DL);
    assign to_clear = rx_data_ready || !in_frame;

    uart_byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (to_clear),
        .enable (in_frame),
        .expire (to_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            cmd_data  <= '0;
            err_pulse <= 1'b0;
            err_code  <= '0;
            frame_cnt <= '0;
            err_cnt   <= '0;
            cmd_r     <= '0;
            dh_r      <= '0;
            dl_r      <= '0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_data_ready && (rx_data == HEADER)) begin
                        state <= HDR_OK;
                        busy  <= 1'b1;
                    end
                end
                HDR_OK, GOT_CMD, GOT_DH, GOT_DL: begin
                    // a byte on the expiry cycle takes priority over the timeout
                    if (rx_data_ready) begin
                        case (state)
                            HDR_OK: begin
                                cmd_r <= rx_data;
                                state <= GOT_CMD;
                            end
                            GOT_CMD: begin
                                dh_r  <= rx_data;
                                state <= GOT_DH;
                            end
                            GOT_DH: begin
                                dl_r  <= rx_data;
                                state <= GOT_DL;
                            end
                            default: begin
                                if (frame_csum(cmd_r, dh_r, dl_r) == rx_data) begin
                                    state     <= PEND;
                                    cmd_valid <= 1'b1;
                                    cmd_code  <= cmd_r;
                                    cmd_data  <= {dh_r, dl_r};
                                    frame_cnt <= frame_cnt + 8'd1;
                                end else begin
                                    state     <= IDLE;
                                    busy      <= 1'b0;
                                    err_pulse <= 1'b1;
                                    err_code  <= ERR_CSUM;
                                    err_cnt   <= sat_inc(err_cnt);
                                end
                            end
                        endcase
                    end else if (to_expire) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        err_pulse <= 1'b1;
                        err_code  <= ERR_TO;
                        err_cnt   <= sat_inc(err_cnt);
                    end
                end
                PEND: begin
                    if (rx_data_ready) begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_OVR;
                        err_cnt   <= sat_inc(err_cnt);
                    end
                    if (cmd_ack) begin
                        cmd_valid <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Frame-level controller behind the UART byte receiver.
- Consumes the receiver's one-cycle byte strobes and assembles fixed-length command frames: header, command, data high, data low, checksum.
- Validates each frame and hands the command to the illumination/polarization control logic over a valid/ack handshake.
- Reports checksum, timeout and overrun errors, and keeps frame and error counters.

Parameters:
- HEADER, 8'hAA, start-of-frame byte.
- TIMEOUT_CYC, 50000, maximum clk cycles allowed between bytes inside a frame (1 ms at 50 MHz).
- TO_W, 16, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only while rx_data_ready is high.
- rx_data_ready  in  1  one-cycle strobe, one per received byte.
- cmd_valid  out  1  a validated command is pending; held until acknowledged.
- cmd_code  out  8  command byte; stable while cmd_valid is high.
- cmd_data  out  16  {data_h, data_l}; stable while cmd_valid is high.
- cmd_ack  in  1  consumer accepts the command when cmd_ack and cmd_valid are both high.
- err_pulse  out  1  one-cycle error strobe.
- err_code  out  2  01 = checksum, 10 = timeout, 11 = overrun; holds the last error code.
- frame_cnt  out  8  count of accepted frames; wraps 255 -> 0.
- err_cnt  out  8  count of errors; saturates at 255.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - State goes to IDLE.
  - cmd_valid, err_pulse and busy go to 0.
  - cmd_code, cmd_data, err_code, frame_cnt, err_cnt and the timeout counter go to 0.
  - Reset mid-frame or mid-handshake discards everything. No error is reported for the discarded frame.
- Byte events: all bytes are sampled only on cycles where rx_data_ready = 1. Other cycles never change parse state, except for the timeout logic.
- State transitions:
  - IDLE:
    - Byte == HEADER -> HDR_OK.
    - Any other byte is silently ignored, with no error.
  - HDR_OK: byte -> latch cmd byte, go to GOT_CMD.
  - GOT_CMD: byte -> latch data_h, go to GOT_DH.
  - GOT_DH: byte -> latch data_l, go to GOT_DL.
  - GOT_DL: byte is the checksum.
    - Checksum = (cmd + data_h + data_l) mod 256, computed as an 8-bit sum with carries discarded.
    - Match -> PEND. On the next cycle cmd_valid = 1 and cmd_code/cmd_data are loaded; frame_cnt increments on that same edge.
    - Mismatch -> IDLE, with a checksum error.
  - PEND:
    - cmd_valid stays high and its outputs are frozen until the cycle where cmd_ack = 1.
    - On that edge cmd_valid goes to 0 and the state goes to IDLE.
    - cmd_ack while cmd_valid is low is ignored.
    - Any byte arriving in PEND is dropped and raises an overrun error. The state stays PEND and the pending command is unaffected.
    - If the ack and a byte arrive in the same cycle, the ack is honoured, the byte is dropped, and the overrun is still flagged.
- Timeout:
  - The counter clears on every byte and on entry to IDLE.
  - It increments each cycle in HDR_OK, GOT_CMD, GOT_DH and GOT_DL.
  - If it reaches TIMEOUT_CYC - 1 with no byte in that cycle -> timeout error, go to IDLE.
  - A byte arriving in the same cycle as the expiry wins: the byte is processed and no timeout is raised.
  - No timeout applies in IDLE or PEND.
- Errors:
  - err_pulse is high for exactly one cycle, on the cycle after the detecting edge.
  - err_code is updated on that same edge.
  - err_cnt increments unless it is already 255.
- Latency: from the checksum byte strobe (cycle N) to cmd_valid high is one cycle (N+1).
- Back-to-back frames: a header byte may arrive in the cycle immediately after the ack and is parsed normally.
- A HEADER value occurring inside a frame is treated as data (no resynchronisation).

Decomposition:
- Package uart_cmd_pkg holds:
  - the state enumeration (IDLE, HDR_OK, GOT_CMD, GOT_DH, GOT_DL, PEND);
  - the error code constants ERR_CSUM = 2'b01, ERR_TO = 2'b10, ERR_OVR = 2'b11;
  - default HEADER and TIMEOUT_CYC.
- One sub-module, uart_byte_timer: a loadable timeout counter with clear, enable and expire outputs, parameterised by TIMEOUT_CYC and TO_W.
- Everything else stays in the top FSM.

Test Plan:
- Good frame:
  - Stimulus: bytes AA 01 12 34 47, ack held 3 cycles after cmd_valid.
  - Required: cmd_valid one cycle after the 47 strobe, cmd_code = 01, cmd_data = 1234, frame_cnt = 1, no err_pulse.
- Bad checksum:
  - Stimulus: AA 01 12 34 48.
  - Required: err_pulse once with err_code = 01, err_cnt = 1, cmd_valid stays 0; a following good frame is accepted.
- Timeout, with TIMEOUT_CYC = 100:
  - Stimulus: AA 05 then silence.
  - Required: err_code = 10 pulse about 100 cycles after the 05 strobe, busy = 0 afterwards.
  - Stimulus: a byte landing exactly on the expiry cycle.
  - Required: no error.
- Overrun:
  - Stimulus: a good frame with no ack, then byte 55.
  - Required: err_code = 11 pulse, cmd_code/cmd_data unchanged; an ack then releases the command.
- Filtering and wrap:
  - Stimulus: leading garbage 00 FF 13 before a good frame.
  - Required: silently ignored, frame accepted.
  - Stimulus: 256 good frames.
  - Required: frame_cnt wraps to 0.
  - Stimulus: 300 bad frames.
  - Required: err_cnt holds at 255.
- Reset mid-frame:
  - Stimulus: rst pulsed after AA 01, then a good frame.
  - Required: all outputs return to their reset values with no err_pulse; the good frame is accepted normally.
